// File: rtl/gpio_bank.sv
// GPIO bank: N pad channels with synchronised inputs, output and enable
// registers, per-bit edge interrupts and a registered read port.
module gpio_bank #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sel,
    input  logic [2:0]    addr,
    input  logic          re,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    input  logic [N-1:0]  pin_in,
    output logic [N-1:0]  pin_out,
    output logic [N-1:0]  pin_oe,
    output logic          irq
);

    localparam logic [2:0] A_IN   = 3'd0;
    localparam logic [2:0] A_OUT  = 3'd1;
    localparam logic [2:0] A_OE   = 3'd2;
    localparam logic [2:0] A_SET  = 3'd3;
    localparam logic [2:0] A_CLR  = 3'd4;
    localparam logic [2:0] A_REN  = 3'd5;
    localparam logic [2:0] A_FEN  = 3'd6;
    localparam logic [2:0] A_EVT  = 3'd7;

    logic [N-1:0]  sync_q [SYNC_STAGES];
    logic [N-1:0]  hist_q;
    logic [N-1:0]  out_q,   out_d;
    logic [N-1:0]  oe_q,    oe_d;
    logic [N-1:0]  ren_q,   ren_d;
    logic [N-1:0]  fen_q,   fen_d;
    logic [N-1:0]  event_q, event_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [N-1:0]  in_s;
    logic [N-1:0]  wd;
    logic [N-1:0]  edge_set;
    logic [31:0]   rd_word;
    logic          wr_en;

    // Upper write-data bits have no register behind them when N < 32.
    logic          unused_wdata;
    assign unused_wdata = ^wdata;

    assign in_s     = sync_q[SYNC_STAGES-1];
    assign wd       = wdata[N-1:0];
    assign wr_en    = sel & (&we);
    assign edge_set = (in_s & ~hist_q & ren_q) | (~in_s & hist_q & fen_q);

    assign pin_out  = out_q;
    assign pin_oe   = oe_q;
    assign irq      = |event_q;
    assign rdata    = rdata_q;

    // Pad synchroniser chain plus one-deep history for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            hist_q <= '0;
        end else begin
            sync_q[0] <= pin_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            hist_q <= in_s;
        end
    end

    // Register writes; a new edge beats a software clear of the same bit.
    always_comb begin
        out_d   = out_q;
        oe_d    = oe_q;
        ren_d   = ren_q;
        fen_d   = fen_q;
        event_d = event_q;
        if (wr_en) begin
            unique case (addr)
                A_OUT:   out_d   = wd;
                A_OE:    oe_d    = wd;
                A_SET:   out_d   = out_q | wd;
                A_CLR:   out_d   = out_q & ~wd;
                A_REN:   ren_d   = wd;
                A_FEN:   fen_d   = wd;
                A_EVT:   event_d = event_q & ~wd;
                default: ;
            endcase
        end
        event_d = event_d | edge_set;
    end

    // Read mux samples pre-write register values; SET/CLR read as zero.
    always_comb begin
        rd_word = '0;
        unique case (addr)
            A_IN:    rd_word[N-1:0] = in_s;
            A_OUT:   rd_word[N-1:0] = out_q;
            A_OE:    rd_word[N-1:0] = oe_q;
            A_SET:   rd_word = '0;
            A_CLR:   rd_word = '0;
            A_REN:   rd_word[N-1:0] = ren_q;
            A_FEN:   rd_word[N-1:0] = fen_q;
            A_EVT:   rd_word[N-1:0] = event_q;
            default: rd_word = '0;
        endcase
        rdata_d = (sel & re) ? rd_word : rdata_q;
    end

    // Control and status register state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= '0;
            oe_q    <= '0;
            ren_q   <= '0;
            fen_q   <= '0;
            event_q <= '0;
            rdata_q <= '0;
        end else begin
            out_q   <= out_d;
            oe_q    <= oe_d;
            ren_q   <= ren_d;
            fen_q   <= fen_d;
            event_q <= event_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
